// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle, bit-serial shift/rotate engine.
//
// Moves the operand one bit position per clock under a start/busy/done
// handshake. The result and carry follow the same rules as the single-cycle
// combinational shifter.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   start        in   request, sampled only while busy = 0
//   data         in   [WIDTH-1:0] operand, captured on accepted start
//   opcode       in   [1:0] operation (`SHL_FN, `SHR_FN, `ROL_FN, `ROR_FN)
//   shift_count  in   [CNT_W-1:0] bit positions, captured on accepted start
//   busy         out  high while shifting
//   done         out  one-cycle pulse when shift_out and C are valid
//   shift_out    out  [WIDTH-1:0] working/result register
//   C            out  carry flag, holds with shift_out
//
// Build option:
//   SEQ_SHIFTER_ROT_CARRY_EN - when defined, rotates load C with the bit that
//   wrapped around; otherwise rotates leave C at 0.

`ifndef SHL_FN
`define SHL_FN 2'b00
`endif
`ifndef SHR_FN
`define SHR_FN 2'b01
`endif
`ifndef ROL_FN
`define ROL_FN 2'b10
`endif
`ifndef ROR_FN
`define ROR_FN 2'b11
`endif

module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [1:0]       opcode,
  input  logic [CNT_W-1:0] shift_count,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             C
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    c_d     = c_q;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, which gives back-to-back issue.
      S_IDLE, S_DONE: begin
        if (start) begin
          w_d     = data;
          op_d    = opcode;
          cnt_d   = shift_count;
          c_d     = 1'b0;
          state_d = (shift_count != '0) ? S_SHIFT : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        case (op_q)
          `SHL_FN: begin
            c_d = w_q[WIDTH-1];
            w_d = {w_q[WIDTH-2:0], 1'b0};
          end
          `SHR_FN: begin
            c_d = w_q[0];
            w_d = {1'b0, w_q[WIDTH-1:1]};
          end
          `ROL_FN: begin
`ifdef SEQ_SHIFTER_ROT_CARRY_EN
            c_d = w_q[WIDTH-1];
`endif
            w_d = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
          end
          default: begin
`ifdef SEQ_SHIFTER_ROT_CARRY_EN
            c_d = w_q[0];
`endif
            w_d = {w_q[0], w_q[WIDTH-1:1]};
          end
        endcase
        // The last bit is processed on the same edge that leaves SHIFT.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign shift_out = w_q;
  assign C         = c_q;

endmodule
